// File: rtl/ddr2_host_pkg.sv
// Shared types and helpers for the ddr2_controller host-port arbiter.
// Command encodings, FSM states, tag layout and burst length calculation.
package ddr2_host_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_SCR  = 3'd1,
        CMD_SCW  = 3'd2,
        CMD_BLR  = 3'd3,
        CMD_BLW  = 3'd4,
        CMD_ATR  = 3'd5,
        CMD_ATW  = 3'd6,
        CMD_NOP7 = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_WAIT_RDY,
        ST_ARB,
        ST_ISSUE,
        ST_BLKDATA
    } state_e;

    localparam int FIFO_HIGH_WATER = 63;
    localparam int ID_W            = 3;
    localparam int CNT_W           = 9;
    localparam int TAG_W           = ID_W + CNT_W;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] count;
    } tag_t;

    function automatic logic [CNT_W-1:0] burst_len(input logic [1:0] sz);
        return {4'd0, sz, 3'b000} + 9'd8;
    endfunction

    // Commands that only need NOTFULL to be taken (no data into the write FIFO).
    function automatic logic is_read_cmd(input logic [2:0] c);
        return (c == CMD_SCR) || (c == CMD_BLR);
    endfunction

    function automatic logic returns_data(input logic [2:0] c);
        return (c == CMD_SCR) || (c == CMD_BLR) || (c == CMD_ATR);
    endfunction

    function automatic logic is_nop(input logic [2:0] c);
        return (c == CMD_NOP) || (c == CMD_NOP7);
    endfunction

endpackage

// File: rtl/ddr2_tag_fifo.sv
// In-order FIFO of {requester id, word count} for outstanding read-type commands.
// Simultaneous push and pop are both applied; full/empty derive from a registered count.
module ddr2_tag_fifo
    import ddr2_host_pkg::*;
#(
    parameter int DEPTH = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] push_data,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_host_arbiter.sv
// Round-robin sharing of the ddr2_controller host port among NUM_REQ requesters,
// with back-pressure aware issue, block-write data locking and in-order read return routing.
module ddr2_host_arbiter
    import ddr2_host_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 16
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    input  logic [3*NUM_REQ-1:0]  REQ_CMD,
    input  logic [2*NUM_REQ-1:0]  REQ_SZ,
    input  logic [3*NUM_REQ-1:0]  REQ_OP,
    input  logic [25*NUM_REQ-1:0] REQ_ADDR,
    input  logic [16*NUM_REQ-1:0] REQ_DIN,
    output logic [NUM_REQ-1:0]    REQ_READY,
    output logic [NUM_REQ-1:0]    RSP_VALID,
    output logic [15:0]           RSP_DOUT,
    output logic [24:0]           RSP_RADDR,
    output logic [2:0]            C_CMD,
    output logic [1:0]            C_SZ,
    output logic [2:0]            C_OP,
    output logic [24:0]           C_ADDR,
    output logic [15:0]           C_DIN,
    output logic                  C_FETCHING,
    input  logic                  C_READY,
    input  logic                  C_NOTFULL,
    input  logic                  C_VALIDOUT,
    input  logic [6:0]            C_FILLCOUNT,
    input  logic [15:0]           C_DOUT,
    input  logic [24:0]           C_RADDR,
    output logic                  ERR_UNEXP
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_e             state;
    state_e             state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grantee;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic               found;
    cmd_e               cmd_q;
    logic [1:0]         sz_q;
    logic [2:0]         op_q;
    logic [24:0]        addr_q;
    logic [15:0]        din_q;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   ret_cnt;
    logic [NUM_REQ-1:0] ready_vec;
    logic               grant;
    logic               accept;
    logic               word_take;
    logic               fill_ok;
    logic               issue_ok;
    logic               tag_full;
    logic               tag_empty;
    logic               push;
    logic               pop;
    tag_t               push_tag;
    tag_t               head_tag;

    logic [2:0]         req_cmd  [NUM_REQ];
    logic [1:0]         req_sz   [NUM_REQ];
    logic [2:0]         req_op   [NUM_REQ];
    logic [24:0]        req_addr [NUM_REQ];
    logic [15:0]        req_din  [NUM_REQ];
    logic               eligible [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_cmd[g]  = REQ_CMD[3*g +: 3];
        assign req_sz[g]   = REQ_SZ[2*g +: 2];
        assign req_op[g]   = REQ_OP[3*g +: 3];
        assign req_addr[g] = REQ_ADDR[25*g +: 25];
        assign req_din[g]  = REQ_DIN[16*g +: 16];
        assign eligible[g] = REQ_VALID[g] && !(returns_data(REQ_CMD[3*g +: 3]) && tag_full);
    end

    assign fill_ok  = (C_FILLCOUNT <= 7'(FIFO_HIGH_WATER));
    assign issue_ok = C_NOTFULL && (is_read_cmd(cmd_q) || fill_ok);

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_WAIT_RDY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_vec = '0;
        grant     = 1'b0;
        accept    = 1'b0;
        word_take = 1'b0;
        case (state)
            ST_WAIT_RDY: begin
                if (C_READY) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (found) begin
                    ready_vec[win_idx] = 1'b1;
                    if (!is_nop(req_cmd[win_idx])) begin
                        grant     = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue_ok) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_q == CMD_BLW) ? ST_BLKDATA : ST_ARB;
                end
            end
            ST_BLKDATA: begin
                if (REQ_VALID[grantee] && fill_ok) begin
                    ready_vec[grantee] = 1'b1;
                    word_take          = 1'b1;
                    if (remaining == 9'd1) begin
                        state_nxt = ST_ARB;
                    end
                end
            end
            default: state_nxt = ST_WAIT_RDY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_q     <= CMD_NOP;
            sz_q      <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            rr_ptr    <= PTR_W'(NUM_REQ - 1);
            grantee   <= '0;
            remaining <= '0;
        end else begin
            if (grant) begin
                cmd_q   <= cmd_e'(req_cmd[win_idx]);
                sz_q    <= req_sz[win_idx];
                op_q    <= req_op[win_idx];
                addr_q  <= req_addr[win_idx];
                din_q   <= req_din[win_idx];
                rr_ptr  <= win_idx;
                grantee <= win_idx;
            end
            if (accept) begin
                cmd_q <= CMD_NOP;
                if (cmd_q == CMD_BLW) begin
                    remaining <= burst_len(sz_q) - 9'd1;
                end
            end
            if (word_take) begin
                remaining <= remaining - 9'd1;
            end
        end
    end

    assign push           = accept && returns_data(cmd_q);
    assign push_tag.id    = ID_W'(grantee);
    assign push_tag.count = (cmd_q == CMD_BLR) ? burst_len(sz_q) : 9'd1;
    assign pop            = C_VALIDOUT && !tag_empty && ((ret_cnt + 9'd1) == head_tag.count);

    ddr2_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (CLK),
        .reset     (RESET),
        .push      (push),
        .push_data (push_tag),
        .pop       (pop),
        .head      (head_tag),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // Returned words are steered to the oldest outstanding read; data with no owner is dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RSP_VALID <= '0;
            RSP_DOUT  <= '0;
            RSP_RADDR <= '0;
            ERR_UNEXP <= 1'b0;
            ret_cnt   <= '0;
        end else begin
            RSP_VALID <= '0;
            if (C_VALIDOUT) begin
                if (tag_empty) begin
                    ERR_UNEXP <= 1'b1;
                end else begin
                    RSP_VALID <= NUM_REQ'(1) << head_tag.id;
                    RSP_DOUT  <= C_DOUT;
                    RSP_RADDR <= C_RADDR;
                    ret_cnt   <= pop ? '0 : ret_cnt + 9'd1;
                end
            end
        end
    end

    assign REQ_READY  = RESET ? '0 : ready_vec;
    assign C_FETCHING = !RESET;
    assign C_CMD      = cmd_q;
    assign C_SZ       = sz_q;
    assign C_OP       = op_q;
    assign C_ADDR     = addr_q;
    assign C_DIN      = (state == ST_BLKDATA) ? req_din[grantee] : din_q;

endmodule
